// File: rtl/cmd_frame_fifo_pkg.sv
// Shared sizing helpers for the frame FIFO: slot/length derivation and the
// length-record width, which needs one extra bit so a full MAXLEN frame fits.
package cmd_frame_fifo_pkg;

  function automatic int exp2(input int n);
    return 1 << n;
  endfunction

  function automatic int len_rec_w(input int len_aw);
    return len_aw + 1;
  endfunction

endpackage

// File: rtl/cmd_idle_timer.sv
// Idle counter: clears on clr, counts while en, saturates; expire is combinational
// and fires on the cycle whose edge would bring the count to TIMEOUT.
module cmd_idle_timer #(
  parameter int TIMEOUT = 1,
  parameter int TO_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/cmd_frame_fifo.sv
// Frame FIFO: whole frames written word-by-word, committed, then read out in order.
// Read data 1 cycle after ren; writes are rejected (wr_drop) when full or frame at MAXLEN.
module cmd_frame_fifo
  import cmd_frame_fifo_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SLOT_AW = 2,
  parameter int LEN_AW  = 4,
  parameter int TIMEOUT = 0,
  parameter int TO_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wen,
  input  logic [WIDTH-1:0]    din,
  input  logic                wr_end,
  input  logic                wr_abort,
  output logic                wr_full,
  output logic                wr_drop,
  output logic                frm_commit,
  input  logic                ren,
  input  logic                rd_skip,
  output logic                rd_valid,
  output logic [WIDTH-1:0]    dout,
  output logic                rd_last,
  output logic                rd_frm_avail,
  output logic [LEN_AW:0]     rd_frm_len,
  output logic [SLOT_AW:0]    frames_used
);

  localparam int SLOTS  = exp2(SLOT_AW);
  localparam int MAXLEN = exp2(LEN_AW);
  localparam int LW     = len_rec_w(LEN_AW);

  logic [WIDTH-1:0] mem [SLOTS*MAXLEN];
  logic [LW-1:0]    lens [SLOTS];

  logic [SLOT_AW:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]      wr_len;
  logic [LEN_AW-1:0]  rd_off;

  logic               wr_ok, wr_acc, commit, to_exp;
  logic [LW-1:0]      eff_len;
  logic [SLOT_AW-1:0] head;
  logic [LW-1:0]      head_len;
  logic               rd_go, at_last, rd_free;

  assign frames_used  = wr_ptr - rd_ptr;
  assign wr_full      = (frames_used == (SLOT_AW+1)'(SLOTS));
  assign rd_frm_avail = (frames_used != '0);

  assign wr_ok   = wen && !wr_full && (wr_len < LW'(MAXLEN));
  assign wr_acc  = wr_ok && !wr_abort;
  assign eff_len = wr_len + LW'(wr_acc);
  assign commit  = !wr_abort && (wr_end || to_exp) && (eff_len != '0);

  generate
    if (TIMEOUT != 0) begin : g_to
      logic to_clr, to_en;
      // Timer only runs on an open frame with no write activity.
      assign to_clr = wr_acc || wr_abort || commit || (wr_len == '0);
      assign to_en  = (wr_len != '0) && !wen;
      cmd_idle_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
      ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (to_clr),
        .en     (to_en),
        .expire (to_exp)
      );
    end else begin : g_no_to
      assign to_exp = 1'b0;
    end
  endgenerate

  assign head       = rd_ptr[SLOT_AW-1:0];
  assign head_len   = lens[head];
  assign rd_frm_len = rd_frm_avail ? head_len : '0;
  assign rd_go      = ren && !rd_skip && rd_frm_avail;
  assign at_last    = ({1'b0, rd_off} == (head_len - LW'(1)));
  assign rd_free    = rd_frm_avail && (rd_skip || (rd_go && at_last));

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[{wr_ptr[SLOT_AW-1:0], wr_len[LEN_AW-1:0]}] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      wr_len     <= '0;
      wr_drop    <= 1'b0;
      frm_commit <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        lens[i] <= '0;
      end
    end else begin
      wr_drop    <= wen && !wr_abort && !wr_ok;
      frm_commit <= commit;
      if (wr_abort) begin
        wr_len <= '0;
      end else if (commit) begin
        lens[wr_ptr[SLOT_AW-1:0]] <= eff_len;
        wr_ptr <= wr_ptr + 1'b1;
        wr_len <= '0;
      end else if (wr_acc) begin
        wr_len <= wr_len + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      rd_off   <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      dout     <= '0;
    end else begin
      rd_valid <= rd_go;
      rd_last  <= rd_go && at_last;
      if (rd_go) begin
        dout <= mem[{head, rd_off}];
      end
      // Freeing on the last-word edge lets the next frame start without a bubble.
      if (rd_free) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_off <= '0;
      end else if (rd_go) begin
        rd_off <= rd_off + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_frame_fifo.sv
// Directed bench for cmd_frame_fifo (TIMEOUT=5); read data checked by a queue-based
// monitor, write/status side checked inline.
module tb_cmd_frame_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wen = 1'b0, wr_end = 1'b0, wr_abort = 1'b0, ren = 1'b0, rd_skip = 1'b0;
  logic [7:0] din = '0;
  logic       wr_full, wr_drop, frm_commit, rd_valid, rd_last, rd_frm_avail;
  logic [7:0] dout;
  logic [4:0] rd_frm_len;
  logic [2:0] frames_used;

  int nchk = 0;
  int nerr = 0;
  logic [8:0] exq[$];

  cmd_frame_fifo #(
    .WIDTH(8), .SLOT_AW(2), .LEN_AW(4), .TIMEOUT(5), .TO_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wen(wen), .din(din), .wr_end(wr_end), .wr_abort(wr_abort),
    .wr_full(wr_full), .wr_drop(wr_drop), .frm_commit(frm_commit),
    .ren(ren), .rd_skip(rd_skip), .rd_valid(rd_valid), .dout(dout),
    .rd_last(rd_last), .rd_frm_avail(rd_frm_avail), .rd_frm_len(rd_frm_len),
    .frames_used(frames_used)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic e);
    wen = 1'b1; din = d; wr_end = e;
    step();
    wen = 1'b0; wr_end = 1'b0;
  endtask

  task automatic rd(input logic [7:0] d, input logic l);
    exq.push_back({d, l});
    ren = 1'b1;
    step();
    ren = 1'b0;
  endtask

  // Read-side monitor: every presented word must match the next expectation.
  initial begin : monitor
    logic [8:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rd_valid) begin
        nchk++;
        if (exq.size() == 0) begin
          nerr++;
          $display("FAIL rd_data: unexpected word %h last %0d", dout, rd_last);
        end else begin
          e = exq.pop_front();
          if ({dout, rd_last} != e) begin
            nerr++;
            $display("FAIL rd_data: got %h last %0d expected %h last %0d",
                     dout, rd_last, e[8:1], e[0]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int drops;
    #12;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_frames_used", frames_used, 0);
    chk("rst_wr_full", wr_full, 0);
    chk("rst_avail", rd_frm_avail, 0);
    chk("rst_frm_len", rd_frm_len, 0);
    chk("rst_commit", frm_commit, 0);
    rst_n = 1'b1;
    step();

    // Basic 3-word frame
    wr(8'h11, 0); wr(8'h22, 0); wr(8'h33, 1);
    chk("t1_commit", frm_commit, 1);
    chk("t1_len", rd_frm_len, 3);
    chk("t1_used", frames_used, 1);
    rd(8'h11, 0); rd(8'h22, 0); rd(8'h33, 1);
    chk("t1_used_after", frames_used, 0);
    chk("t1_commit_pulse", frm_commit, 0);

    // Over-long frame truncated to 16
    drops = 0;
    for (int i = 0; i < 17; i++) begin
      wr(8'h40 + 8'(i), (i == 16));
      drops += int'(wr_drop);
    end
    chk("t2_drop_17th", wr_drop, 1);
    chk("t2_drop_count", drops, 1);
    chk("t2_commit", frm_commit, 1);
    chk("t2_len", rd_frm_len, 16);
    step();
    chk("t2_drop_pulse", wr_drop, 0);
    for (int i = 0; i < 16; i++) rd(8'h40 + 8'(i), (i == 15));
    chk("t2_used_after", frames_used, 0);

    // Fill all slots, reject, free one, wrap
    for (int k = 0; k < 4; k++) wr(8'hA0 + 8'(k), 1);
    chk("t3_full", wr_full, 1);
    chk("t3_used", frames_used, 4);
    wr(8'hEE, 1);
    chk("t3_drop_full", wr_drop, 1);
    chk("t3_no_commit_full", frm_commit, 0);
    rd(8'hA0, 1);
    chk("t3_nonfull", wr_full, 0);
    chk("t3_used3", frames_used, 3);
    wr(8'hB0, 1);
    chk("t3_used_refill", frames_used, 4);
    exq.push_back({8'hA1, 1'b1});
    ren = 1'b1; wen = 1'b1; din = 8'hCC; wr_end = 1'b1;
    step();
    ren = 1'b0; wen = 1'b0; wr_end = 1'b0;
    chk("t3_drop_same_free", wr_drop, 1);
    chk("t3_no_commit_same_free", frm_commit, 0);
    chk("t3_used_same_free", frames_used, 3);
    rd(8'hA2, 1); rd(8'hA3, 1); rd(8'hB0, 1);
    chk("t3_used_after", frames_used, 0);

    // Idle timeout commit
    wr(8'h51, 0); wr(8'h52, 0);
    for (int k = 1; k <= 4; k++) step();
    chk("t4_no_commit_early", frm_commit, 0);
    chk("t4_used_early", frames_used, 0);
    step();
    chk("t4_timeout_commit", frm_commit, 1);
    chk("t4_len", rd_frm_len, 2);
    wr_end = 1'b1; step(); wr_end = 1'b0;
    chk("t4_empty_end", frm_commit, 0);
    chk("t4_used", frames_used, 1);
    rd(8'h51, 0); rd(8'h52, 1);

    // Abort then short frame; skip a head frame
    wr(8'h61, 0); wr(8'h62, 0);
    wr_abort = 1'b1; wen = 1'b1; din = 8'h63;
    step();
    wr_abort = 1'b0; wen = 1'b0;
    chk("t5_abort_drop", wr_drop, 0);
    chk("t5_abort_commit", frm_commit, 0);
    wr(8'h64, 1);
    chk("t5_len_after_abort", rd_frm_len, 1);
    wr(8'h71, 0); wr(8'h72, 0); wr(8'h73, 1); wr(8'h81, 1);
    chk("t5_used", frames_used, 3);
    rd(8'h64, 1);
    chk("t5_head_len", rd_frm_len, 3);
    rd_skip = 1'b1; ren = 1'b1;
    step();
    rd_skip = 1'b0; ren = 1'b0;
    chk("t5_skip_valid", rd_valid, 0);
    chk("t5_skip_len", rd_frm_len, 1);
    chk("t5_skip_used", frames_used, 1);
    rd(8'h81, 1);

    // Back-to-back frames, no gap
    wr(8'h91, 0); wr(8'h92, 1); wr(8'h93, 1);
    rd(8'h91, 0); chk("t6_v0", rd_valid, 1);
    rd(8'h92, 1); chk("t6_v1", rd_valid, 1);
    rd(8'h93, 1); chk("t6_v2", rd_valid, 1);

    // Asynchronous reset mid-read
    wr(8'hC1, 0); wr(8'hC2, 0); wr(8'hC3, 1);
    rd(8'hC1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", rd_valid, 0);
    chk("t7_rst_dout", dout, 0);
    chk("t7_rst_used", frames_used, 0);
    chk("t7_rst_len", rd_frm_len, 0);
    rst_n = 1'b1;
    step();
    chk("t7_used_release", frames_used, 0);
    chk("t7_avail_release", rd_frm_avail, 0);
    step(); step();
    chk("queue_empty", exq.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/cmd_frame_fifo.md
Name: cmd_frame_fifo

Overview:
Frame-oriented command FIFO. It buffers whole command frames written byte-by-byte from the RS422 receive path and hands them to the command decoder one frame at a time. It is the parametrised successor to the existing single-mode command FIFO and adds:
- a full-length frame record, so a maximum-length frame is valid;
- an idle-timeout frame end;
- write abort and read skip;
- overflow reporting and per-frame length on the read side.

Parameters:
WIDTH, 8, data word width
SLOT_AW, 2, log2 of frame slot count (SLOTS = 2^SLOT_AW)
LEN_AW, 4, log2 of max words per frame (MAXLEN = 2^LEN_AW)
TIMEOUT, 0, idle cycles after the last accepted word before auto-commit; 0 disables
TO_W, 16, timeout counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wen  in  1  write strobe, one word per cycle
din  in  WIDTH  write data
wr_end  in  1  end of current frame (commit)
wr_abort  in  1  discard current frame in progress
wr_full  out  1  no free slot; all SLOTS frames committed
wr_drop  out  1  1-cycle pulse: a wen word was rejected
frm_commit  out  1  1-cycle pulse: a frame was committed
ren  in  1  read strobe
rd_skip  in  1  discard head frame unread
rd_valid  out  1  dout valid, 1 cycle after accepted ren
dout  out  WIDTH  read data, registered
rd_last  out  1  qualifies final word of frame, aligned with rd_valid
rd_frm_avail  out  1  at least one committed frame present
rd_frm_len  out  LEN_AW+1  word count of head frame (1..MAXLEN), 0 if none
frames_used  out  SLOT_AW+1  committed frames held (0..SLOTS)

Behaviour:
- Reset: all outputs 0; pointers, offsets, length records and timeout counter cleared. A frame being received or read at reset is lost. Reset is asynchronous; recovery is synchronous.
- Storage: SLOTS x MAXLEN words, plus a length record of LEN_AW+1 bits per slot.
- Write pointers: slot pointer is SLOT_AW+1 bits with a wrap bit. Write offset wr_len is LEN_AW+1 bits.
- Write accept condition: wen && !wr_full && wr_len < MAXLEN. On accept, the word is stored at [wr_slot][wr_len] and wr_len increments.
- Write reject: wen that is not accepted (full, or wr_len == MAXLEN) produces a wr_drop pulse on the next cycle. The frame in progress is kept, so an over-long frame is truncated to MAXLEN.
- Commit trigger: wr_end, or the timeout expiring, while the effective length > 0.
  - Effective length = wr_len + (word accepted this cycle), so wen together with wr_end includes that word.
  - On commit: store the length, advance the slot pointer, clear wr_len; frm_commit pulses next cycle.
  - wr_end with effective length 0 is ignored; empty frames are never committed.
- Abort: wr_abort has priority over wr_end, the timeout and wen. It clears wr_len and any word presented that cycle is discarded. No commit, no drop pulse.
- Timeout:
  - The counter clears on each accepted word and counts while wr_len > 0 with no wen.
  - Reaching TIMEOUT commits exactly as wr_end does, then the counter clears.
  - The counter saturates; it never wraps.
- wr_full: frames_used == SLOTS, computed combinationally from the pointers.
- Read: rd_frm_avail = frames_used != 0. rd_frm_len is the length record of the head slot (0 when empty).
  - ren when rd_frm_avail: dout <= [rd_slot][rd_off], with rd_valid = 1 on the next cycle.
  - rd_last = 1 when rd_off == len-1. On that same edge the head slot is freed and rd_off cleared, so the next frame can be read on the very next cycle with no bubble.
  - ren with no frame available: ignored, rd_valid = 0, dout holds its value.
- rd_skip has priority over ren. When a frame is available it frees the head slot and clears rd_off; rd_valid = 0 that cycle. With no frame available it is a no-op.
- Simultaneous commit and free (last-word read or skip) in one cycle: frames_used is unchanged, and both pointers advance.
- Full-to-nonfull: a word presented in the same cycle the last head frame is freed is still rejected, because wr_full is evaluated before the edge.
- Wrap-around: slot pointers wrap modulo SLOTS. The wrap bit distinguishes full from empty: pointer indices equal with wrap bits differing = full; pointers fully equal = empty.

Decomposition:
- Shared package/header: exp2 function; SLOTS/MAXLEN localparam derivation; the rule "length record width = LEN_AW+1".
- One sub-module, cmd_idle_timer: TIMEOUT/TO_W counter with clear, enable and a 1-cycle expire pulse. Instantiated only under TIMEOUT != 0; otherwise its expire output is tied 0.

Test Plan:
- Default params: write 3 words 0x11,0x22,0x33, with wr_end on the 3rd wen -> frm_commit pulse, rd_frm_len=3, frames_used=1; 3 ren -> dout 0x11,0x22,0x33 with rd_last only on 0x33, then frames_used=0.
- Write 17 words then wr_end (MAXLEN=16) -> one wr_drop pulse on the 17th; rd_frm_len=16, read-back shows the first 16 words intact.
- Commit 4 one-word frames -> wr_full=1, frames_used=4; a 5th wen gives wr_drop. Read 1 frame -> wr_full=0; a new frame commits into the wrapped slot 0 and reads back in FIFO order.
- TIMEOUT=5: write 2 words then idle -> commit exactly 5 cycles after the last wen. wr_end with an empty frame -> no commit.
- wr_abort after 2 words, then 1 word + wr_end -> rd_frm_len=1. rd_skip on a 3-word head frame -> the next frame is presented, rd_valid stays 0.
- Continuous ren across two committed frames -> no gap between frames. Assert rst_n=0 mid-read -> all outputs 0 asynchronously, frames_used=0 after release.
